mini_core_dmem_rsp: RTL



---
 rtl/mini_core_dmem_rsp_if.sv | 22 ++
 rtl/mini_core_dmem_rsp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mini_core_dmem_rsp_if.sv
// Load/store request and response bundle between the core (master) and the data memory (slave).
interface mini_core_dmem_rsp_if;
   logic [31:0] ReqAddressQ103H;
   logic [31:0] ReqWrDataQ103H;
   logic [3:0]  ReqByteEnQ103H;
   logic        ReqWrEnQ103H;
   logic        ReqRdEnQ103H;
   logic        DMemReady;
   logic [31:0] DMemRdRspQ104H;
   logic        RdRspValidQ104H;
   logic        AccessErr;

   modport master (
      output ReqAddressQ103H, ReqWrDataQ103H, ReqByteEnQ103H, ReqWrEnQ103H, ReqRdEnQ103H,
      input  DMemReady, DMemRdRspQ104H, RdRspValidQ104H, AccessErr
   );

   modport slave (
      input  ReqAddressQ103H, ReqWrDataQ103H, ReqByteEnQ103H, ReqWrEnQ103H, ReqRdEnQ103H,
      output DMemReady, DMemRdRspQ104H, RdRspValidQ104H, AccessErr
   );
endinterface

// File: rtl/mini_core_dmem_rsp.sv
// Data-memory responder: byte-enabled word array, 1-cycle read response, programmable read wait states.
module mini_core_dmem_rsp #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
   parameter int unsigned RD_WAIT    = 0
) (
   input logic                  Clock,
   input logic                  Rst,
   mini_core_dmem_rsp_if.slave  bus
);

   localparam int unsigned IDX_W = ADDR_WIDTH - 2;
   localparam int unsigned DEPTH = 2 ** IDX_W;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q;
   logic               in_range_q;
   logic [31:0]        rd_data_q;
   logic               rd_valid_q;
   logic               err_q;
   logic [31:0]        mem [DEPTH];

   logic               in_range;
   logic [IDX_W-1:0]   req_idx;
   logic               req_rd_only;
   logic               ready_c;
   logic               wr_acc_c;
   logic               rd_acc_c;
   logic [IDX_W-1:0]   rd_idx_c;
   logic               rd_in_range_c;
   logic               unused_addr_lsb;

   assign in_range        = (bus.ReqAddressQ103H[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
   assign req_idx         = bus.ReqAddressQ103H[ADDR_WIDTH-1:2];
   assign req_rd_only     = bus.ReqRdEnQ103H & ~bus.ReqWrEnQ103H;
   assign unused_addr_lsb = ^{bus.ReqAddressQ103H[1:0], BASE_ADDR[ADDR_WIDTH-1:0]};

   // State and wait-counter register.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: a plain read (not a combined store) enters WAIT when wait states are configured.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if ((RD_WAIT > 0) && req_rd_only) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(RD_WAIT - 1);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Ready and acceptance strobes; in WAIT the read uses the address sampled on entry.
   always_comb begin
      ready_c       = 1'b1;
      wr_acc_c      = 1'b0;
      rd_acc_c      = 1'b0;
      rd_idx_c      = req_idx;
      rd_in_range_c = in_range;
      case (state_q)
         ST_IDLE: begin
            if ((RD_WAIT > 0) && req_rd_only) begin
               ready_c = 1'b0;
            end else begin
               wr_acc_c = bus.ReqWrEnQ103H;
               rd_acc_c = req_rd_only;
            end
         end
         ST_WAIT: begin
            ready_c       = (cnt_q == '0);
            rd_acc_c      = (cnt_q == '0);
            rd_idx_c      = idx_q;
            rd_in_range_c = in_range_q;
         end
         default: ready_c = 1'b1;
      endcase
   end

   // Capture the read address when the stall begins.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         idx_q      <= '0;
         in_range_q <= 1'b0;
      end else if ((state_q == ST_IDLE) && (state_d == ST_WAIT)) begin
         idx_q      <= req_idx;
         in_range_q <= in_range;
      end
   end

   // Byte-lane write into the array; contents are not reset.
   always_ff @(posedge Clock) begin
      if (wr_acc_c && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.ReqByteEnQ103H[i]) mem[req_idx][8*i +: 8] <= bus.ReqWrDataQ103H[8*i +: 8];
         end
      end
   end

   // Read response: one-cycle valid pulse, data held until the next accepted read.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc_c;
         if (rd_acc_c) rd_data_q <= rd_in_range_c ? mem[rd_idx_c] : 32'h0;
      end
   end

   // Sticky error: out-of-range access or a store issued together with a load.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         err_q <= 1'b0;
      end else if ((wr_acc_c && (!in_range || bus.ReqRdEnQ103H)) || (rd_acc_c && !rd_in_range_c)) begin
         err_q <= 1'b1;
      end
   end

   assign bus.DMemReady       = ready_c;
   assign bus.DMemRdRspQ104H  = rd_data_q;
   assign bus.RdRspValidQ104H = rd_valid_q;
   assign bus.AccessErr       = err_q;

endmodule
